// File: rtl/alu_dword_seq_pkg.sv
// Shared definitions for the sequenced 32-bit ALU: widths, request/ALU op codes and FSM states.
// Also provides the request-to-ALU opcode mapping.
package alu_dword_seq_pkg;

    localparam int unsigned WordSize  = 16;
    localparam int unsigned DwordSize = 2 * WordSize;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpOr  = 2'b11
    } req_op_e;

    typedef enum logic [1:0] {
        AluOpAdd = 2'b00,
        AluOpSub = 2'b01,
        AluOpAnd = 2'b10,
        AluOpOrr = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLo   = 2'b01,
        StHi   = 2'b10,
        StResp = 2'b11
    } state_e;

    function automatic alu_op_e to_alu_op(input req_op_e op);
        alu_op_e res;
        unique case (op)
            OpAdd:   res = AluOpAdd;
            OpSub:   res = AluOpSub;
            OpAnd:   res = AluOpAnd;
            default: res = AluOpOrr;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_dword_seq_alu.sv
// 16-bit ALU: add/sub with carry/borrow in and out, bitwise AND/OR, unsigned compare.
// Cout is forced to 0 for the logic ops.
module alu_dword_seq_alu
    import alu_dword_seq_pkg::*;
(
    input  alu_op_e             op,
    input  logic [WordSize-1:0] a,
    input  logic [WordSize-1:0] b,
    input  logic                cin,
    output logic [WordSize-1:0] result,
    output logic                cout,
    output logic [1:0]          compare
);

    logic [WordSize:0] sum;
    logic [WordSize:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{WordSize{1'b0}}, cin};
        // Cin acts as borrow-in; the top bit of the extended difference is the borrow-out.
        diff = {1'b0, a} - {1'b0, b} - {{WordSize{1'b0}}, cin};
        result = '0;
        cout   = 1'b0;
        unique case (op)
            AluOpAdd: begin
                result = sum[WordSize-1:0];
                cout   = sum[WordSize];
            end
            AluOpSub: begin
                result = diff[WordSize-1:0];
                cout   = diff[WordSize];
            end
            AluOpAnd: result = a & b;
            default:  result = a | b;
        endcase
    end

    always_comb begin
        if (a == b) begin
            compare = 2'b00;
        end else if (a > b) begin
            compare = 2'b10;
        end else begin
            compare = 2'b11;
        end
    end

endmodule

// File: rtl/alu_dword_seq.sv
// 32-bit ADD/SUB/AND/OR executed as low then high pass through one shared 16-bit ALU.
// Optional 32-bit SUB compare code built only when ALU_SEQ_CMP_EN is defined.
module alu_dword_seq
    import alu_dword_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [DwordSize-1:0] req_a,
    input  logic [DwordSize-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DwordSize-1:0] rsp_result,
    output logic                 rsp_cout,
    output logic [1:0]           rsp_cmp
);

    state_e state_q, state_d;

    req_op_e             op_q;
    logic [DwordSize-1:0] a_q, b_q;
    logic [WordSize-1:0]  lo_q;
    logic                 carry_q;
    logic [DwordSize-1:0] result_q;
    logic                 cout_q;

    logic                accept;
    logic [WordSize-1:0] alu_a, alu_b, alu_result;
    logic                alu_cin, alu_cout;
    logic [1:0]          alu_cmp_unused;

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StLo;
            StLo:   state_d = StHi;
            StHi:   state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = accept ? StLo : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);
        rsp_valid = (state_q == StResp);
        if (state_q == StHi) begin
            alu_a   = a_q[DwordSize-1:WordSize];
            alu_b   = b_q[DwordSize-1:WordSize];
            alu_cin = ((op_q == OpAdd) || (op_q == OpSub)) ? carry_q : 1'b0;
        end else begin
            alu_a   = a_q[WordSize-1:0];
            alu_b   = b_q[WordSize-1:0];
            alu_cin = 1'b0;
        end
    end

    alu_dword_seq_alu u_alu (
        .op      (to_alu_op(op_q)),
        .a       (alu_a),
        .b       (alu_b),
        .cin     (alu_cin),
        .result  (alu_result),
        .cout    (alu_cout),
        .compare (alu_cmp_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OpAdd;
            a_q      <= '0;
            b_q      <= '0;
            lo_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= req_op_e'(req_op);
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (state_q == StLo) begin
                lo_q    <= alu_result;
                carry_q <= alu_cout;
            end
            if (state_q == StHi) begin
                result_q <= {alu_result, lo_q};
                cout_q   <= alu_cout;
            end
        end
    end

    assign rsp_result = result_q;
    assign rsp_cout   = cout_q;

`ifdef ALU_SEQ_CMP_EN
    logic [1:0]           cmp_q;
    logic [DwordSize-1:0] full_diff;

    assign full_diff = {alu_result, lo_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q <= 2'b00;
        end else if (state_q == StHi) begin
            if ((op_q == OpSub) && (full_diff != '0)) begin
                cmp_q <= {1'b1, full_diff[DwordSize-1]};
            end else begin
                cmp_q <= 2'b00;
            end
        end
    end

    assign rsp_cmp = cmp_q;
`else
    assign rsp_cmp = 2'b00;
`endif

endmodule

// File: tb/tb_alu_dword_seq.sv
// Scoreboard bench for alu_dword_seq: directed vectors push expectations, a monitor pops on
// each response handshake. Expected compare codes follow ALU_SEQ_CMP_EN.
module tb_alu_dword_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout;
    logic [1:0]  rsp_cmp;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic [1:0]  cmp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef ALU_SEQ_CMP_EN
    localparam bit CmpEn = 1'b1;
`else
    localparam bit CmpEn = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_dword_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .rsp_cmp    (rsp_cmp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] sub_cmp(input logic [1:0] code);
        return CmpEn ? code : 2'b00;
    endfunction

    // Monitor: a response is consumed at the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got 0x%08h, expected no response", rsp_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".result"}, rsp_result, e.res);
                check({e.name, ".cout"}, {31'b0, rsp_cout}, {31'b0, e.cout});
                check({e.name, ".cmp"}, {30'b0, rsp_cmp}, {30'b0, e.cmp});
            end
        end
    end

    // Called at posedge+#1; returns at accept edge+#1 with inputs scrambled.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eres, input logic ecout,
                         input logic [1:0] ecmp, input string name);
        bit ok = 1'b0;
        if (push) sb.push_back('{res: eres, cout: ecout, cmp: ecmp, name: name});
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.accept: got req_ready=0, expected 1 within 20 cycles", name);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'h5A5A_A5A5;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.req_ready", {31'b0, req_ready}, 32'd1);
        check("reset.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset.rsp_result", rsp_result, 32'h0);
        check("reset.rsp_cout", {31'b0, rsp_cout}, 32'd0);
        check("reset.rsp_cmp", {30'b0, rsp_cmp}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Latency: valid exactly two edges after the accept edge.
        issue(2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0000, 1'b0, 2'b00, "add_carry16");
        check("lat.edge0_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat.edge1_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat.edge2_valid", {31'b0, rsp_valid}, 32'd1);
        drain();

        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 2'b00, "add_wrap");
        drain();
        issue(2'b00, 32'h7FFF_8000, 32'h0000_8000, 1'b1, 32'h8000_0000, 1'b0, 2'b00, "add_mid");
        drain();
        issue(2'b01, 32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b0, sub_cmp(2'b10),
              "sub_borrow16");
        drain();
        issue(2'b01, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b0, 2'b00, "sub_eq");
        drain();
        issue(2'b01, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, sub_cmp(2'b11),
              "sub_zero_m1");
        drain();
        issue(2'b11, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 32'hA5A5_5A5A, 1'b0, 2'b00, "or_basic");
        drain();

        // Back-pressure with SUB 3-5 held in RESP, then a same-edge accept of AND.
        rsp_ready = 1'b0;
        issue(2'b01, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b1, sub_cmp(2'b11),
              "sub_neg");
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) break;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.valid", {31'b0, rsp_valid}, 32'd1);
            check("bp.req_ready", {31'b0, req_ready}, 32'd0);
            check("bp.result", rsp_result, 32'hFFFF_FFFE);
            check("bp.cout", {31'b0, rsp_cout}, 32'd1);
            check("bp.cmp", {30'b0, rsp_cmp}, {30'b0, sub_cmp(2'b11)});
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        issue(2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0, 2'b00, "and_b2b");
        // Accepted straight from RESP: now in LO, so no response is visible.
        check("b2b.valid_after_accept", {31'b0, rsp_valid}, 32'd0);
        check("b2b.req_ready_in_lo", {31'b0, req_ready}, 32'd0);
        drain();

        // Reset while in HI of an ADD drops the op.
        issue(2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h0, 1'b0, 2'b00, "add_dropped");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_hi.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_hi.req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("rst_hi.still_idle", {31'b0, rsp_valid}, 32'd0);
        issue(2'b11, 32'h1234_0000, 32'h0000_5678, 1'b1, 32'h1234_5678, 1'b0, 2'b00, "or_after_rst");
        drain();

        check("sb.empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
